// File: rtl/div_requester.sv
// div_requester: initiator side of the divider req/values/ack/result handshake.
// Takes a dividend/divisor command, issues it to the divider, and returns
// quotient/remainder or an error. Only one transaction is in flight at a time.
// Optional feature macro: DIV_REQUESTER_ZERO_BYPASS_EN. When it is defined, a
// divisor of zero is answered with an error directly and is never sent to the
// divider.
module div_requester #(
    parameter int unsigned W           = 8,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [W-1:0]   cmd_dividend,
    input  logic [W-1:0]   cmd_divisor,
    output logic           div_req,
    output logic [2*W-1:0] div_values,
    input  logic           div_ack,
    input  logic [2*W-1:0] div_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_quotient,
    output logic [W-1:0]   rsp_remainder,
    output logic           rsp_error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     dividend_q, dividend_d;
    logic [W-1:0]     divisor_q, divisor_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             div_req_q, div_req_d;
    logic [2*W-1:0]   div_values_q, div_values_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_quotient_q, rsp_quotient_d;
    logic [W-1:0]     rsp_remainder_q, rsp_remainder_d;
    logic             rsp_error_q, rsp_error_d;

    // Next-state, operand/response capture and registered output values.
    always_comb begin
        state_d         = state_q;
        dividend_d      = dividend_q;
        divisor_d       = divisor_q;
        count_d         = count_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_error_d     = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    dividend_d = cmd_dividend;
                    divisor_d  = cmd_divisor;
`ifdef DIV_REQUESTER_ZERO_BYPASS_EN
                    if (cmd_divisor == '0) begin
                        rsp_quotient_d  = '0;
                        rsp_remainder_d = '0;
                        rsp_error_d     = 1'b1;
                        state_d         = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ:  state_d = S_LOAD;
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (div_ack) begin
                    rsp_quotient_d  = div_result[2*W-1:W];
                    rsp_remainder_d = div_result[W-1:0];
                    rsp_error_d     = 1'b0;
                    state_d         = S_RESP;
                end else if (count_q == CNT_LAST) begin
                    rsp_quotient_d  = '0;
                    rsp_remainder_d = '0;
                    rsp_error_d     = 1'b1;
                    state_d         = S_RESP;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        div_req_d    = (state_d == S_REQ);
        rsp_valid_d  = (state_d == S_RESP);
        div_values_d = ((state_d == S_LOAD) || (state_d == S_WAIT))
                       ? {dividend_d, divisor_d} : '0;
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            dividend_q      <= '0;
            divisor_q       <= '0;
            count_q         <= '0;
            cmd_ready_q     <= 1'b1;
            div_req_q       <= 1'b0;
            div_values_q    <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            dividend_q      <= dividend_d;
            divisor_q       <= divisor_d;
            count_q         <= count_d;
            cmd_ready_q     <= cmd_ready_d;
            div_req_q       <= div_req_d;
            div_values_q    <= div_values_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_error_q     <= rsp_error_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign div_req       = div_req_q;
    assign div_values    = div_values_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_div_requester.sv
// tb_div_requester: random and directed transactions against a behavioural
// model of the requester plus a simple divider model with programmable ack delay.
module tb_div_requester;

    localparam int W           = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int CNT_W       = 7;

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [W-1:0]   cmd_dividend;
    logic [W-1:0]   cmd_divisor;
    logic           div_req;
    logic [2*W-1:0] div_values;
    logic           div_ack;
    logic [2*W-1:0] div_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic           rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    div_requester #(
        .W(W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dividend(cmd_dividend),
        .cmd_divisor(cmd_divisor),
        .div_req(div_req),
        .div_values(div_values),
        .div_ack(div_ack),
        .div_result(div_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_error(rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full command/response transaction. d = WAIT cycle in which the
    // divider model acks (>= TIMEOUT_CYC means it never acks).
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int d, input int hold);
        logic [W-1:0] mq, mr, eq, er;
        logic         exp_err;
        int           exp_lat;
        bit           byp;
        int           seen;
        bit           req_extra, val_bad, held_bad;

        // Divider model: plain unsigned division; zero divisor gives all-ones/dividend.
        if (b == '0) begin
            mq = '1;
            mr = a;
        end else begin
            mq = a / b;
            mr = a % b;
        end
        byp = 1'b0;
`ifdef DIV_REQUESTER_ZERO_BYPASS_EN
        byp = (b == '0);
`endif
        // Requester reference: ack inside the window passes data, else timeout error.
        if (byp) begin
            exp_err = 1'b1; eq = '0; er = '0; exp_lat = 0;
        end else if (d < TIMEOUT_CYC) begin
            exp_err = 1'b0; eq = mq; er = mr; exp_lat = d + 1;
        end else begin
            exp_err = 1'b1; eq = '0; er = '0; exp_lat = TIMEOUT_CYC;
        end

        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid    = 1'b1;
        cmd_dividend = a;
        cmd_divisor  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);

        if (byp) begin
            check("byp_no_req", 32'(div_req), 32'd0);
            check("byp_rsp_valid", 32'(rsp_valid), 32'd1);
        end else begin
            check("req_pulse", 32'(div_req), 32'd1);
            check("req_values_zero", 32'(div_values), 32'd0);
            @(negedge clk);
            check("load_req_low", 32'(div_req), 32'd0);
            check("load_values", 32'(div_values), 32'({a, b}));

            seen      = -1;
            req_extra = 1'b0;
            val_bad   = 1'b0;
            for (int c = 0; c < TIMEOUT_CYC + 10; c++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    seen    = c;
                    div_ack = 1'b0;
                    break;
                end
                if (div_req) req_extra = 1'b1;
                if (div_values !== {a, b}) val_bad = 1'b1;
                div_ack    = (c == d);
                div_result = {mq, mr};
            end
            div_ack = 1'b0;
            check("rsp_latency", 32'(seen), 32'(exp_lat));
            check("wait_single_req", 32'(req_extra), 32'd0);
            check("wait_values_stable", 32'(val_bad), 32'd0);
        end

        check("rsp_quotient", 32'(rsp_quotient), 32'(eq));
        check("rsp_remainder", 32'(rsp_remainder), 32'(er));
        check("rsp_error", 32'(rsp_error), 32'(exp_err));
        check("resp_values_zero", 32'(div_values), 32'd0);

        // Hold off the response with spurious acks; nothing may move.
        if (hold > 0) begin
            held_bad  = 1'b0;
            req_extra = 1'b0;
            for (int h = 0; h < hold; h++) begin
                div_ack    = 1'($urandom_range(0, 1));
                div_result = 16'($urandom);
                @(negedge clk);
                if (div_req || cmd_ready) req_extra = 1'b1;
                if (!rsp_valid || rsp_quotient !== eq || rsp_remainder !== er ||
                    rsp_error !== exp_err) held_bad = 1'b1;
            end
            div_ack = 1'b0;
            check("rsp_hold_stable", 32'(held_bad), 32'd0);
            check("rsp_hold_no_req", 32'(req_extra), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check("rsp_done_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Ack while idle must not create a response.
    task automatic idle_ack();
        @(negedge clk);
        div_ack    = 1'b1;
        div_result = 16'($urandom);
        @(negedge clk);
        div_ack = 1'b0;
        check("idle_ack_no_rsp", 32'(rsp_valid), 32'd0);
        check("idle_ack_no_req", 32'(div_req), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_dividend = '0;
        cmd_divisor  = '0;
        div_ack      = 1'b0;
        div_result   = '0;
        rsp_ready    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_div_req", 32'(div_req), 32'd0);
        check("rst_div_values", 32'(div_values), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'({rsp_quotient, rsp_remainder, rsp_error}), 32'd0);
        reset = 1'b0;

        // Directed: basic ack after 20 cycles, 100/7 -> 14 r 2.
        run_txn(8'd100, 8'd7, 20, 0);

        // Reset while waiting on the divider, then a late ack.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dividend = 8'd50; cmd_divisor = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_div_req", 32'(div_req), 32'd0);
        check("mid_rst_values", 32'(div_values), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data", 32'({rsp_quotient, rsp_remainder, rsp_error}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_ack();
        check("late_ack_ready", 32'(cmd_ready), 32'd1);

        // Directed corner cases.
        run_txn(8'd200, 8'd9, 1000, 0);              // timeout
        run_txn(8'd77, 8'd5, 3, 10);                 // backpressure
        run_txn(8'd42, 8'd0, 5, 0);                  // zero divisor, acked
        run_txn(8'd42, 8'd0, 1000, 2);               // zero divisor, no ack
        run_txn(8'd255, 8'd16, TIMEOUT_CYC - 1, 0);  // ack coincident with timeout
        run_txn(8'd255, 8'd255, 0, 1);               // fastest ack
        run_txn(8'd0, 8'd1, TIMEOUT_CYC - 2, 0);
        idle_ack();

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            int           rd, rh;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rd = ($urandom_range(0, 5) == 0) ? TIMEOUT_CYC + 5 : int'($urandom_range(0, 70));
            rh = int'($urandom_range(0, 4));
            run_txn(ra, rb, rd, rh);
            if ($urandom_range(0, 3) == 0) idle_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
